// File: rtl/rotation_slicer_pkg.sv
// Shared definitions for the rotation slicer: default widths and FSM encoding.
package rotation_slicer_pkg;

    // Slices per revolution is 2**SLICE_LOG_DEF; must agree with the frame
    // column count used by the downstream frame reader.
    localparam int SLICE_LOG_DEF    = 8;
    localparam int PERIOD_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALIB = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/rotation_slicer_phase_accumulator.sv
// Divider-free phase accumulator: adds 2**SLICE_LOG per clock and subtracts
// the revolution period whenever the sum reaches it, flagging a slice advance.
module rotation_slicer_phase_accumulator #(
    parameter int SLICE_LOG    = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    advance,
    output logic [PERIOD_WIDTH:0]   acc
);

    localparam int AW = PERIOD_WIDTH + 1;
    localparam logic [AW-1:0] STEP = AW'(1) << SLICE_LOG;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] sum;
    logic [AW-1:0] period_ext;
    logic          reach;

    // Candidate sum and threshold compare for this cycle.
    always_comb begin
        period_ext = {1'b0, period};
        sum        = acc_q + STEP;
        reach      = (sum >= period_ext);
        advance    = enable & reach;
        acc_d      = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = reach ? (sum - period_ext) : sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/rotation_slicer.sv
// Angular timebase: measures the revolution period from the index pulse and
// splits each revolution into 2**SLICE_LOG slices with a strobe per slice.
module rotation_slicer
    import rotation_slicer_pkg::*;
#(
    parameter int SLICE_LOG    = SLICE_LOG_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_cycle,
    output logic [SLICE_LOG-1:0]    slice_num,
    output logic                    slice_strobe,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    running
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [SLICE_LOG-1:0]    SLICE_MAX = '1;
    localparam logic [PERIOD_WIDTH:0]   MIN_GAP   = (PERIOD_WIDTH + 1)'(1) << SLICE_LOG;

    state_t                  state_q, state_d;
    logic                    cyc_q;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [SLICE_LOG-1:0]    slice_q, slice_d;
    logic                    strobe_q, strobe_d;

    logic                    rise;
    logic [PERIOD_WIDTH:0]   cnt_inc;
    logic                    stall;
    logic                    take_rise;
    logic                    load;
    logic                    acc_clear;
    logic                    acc_enable;
    logic                    advance;
    logic [PERIOD_WIDTH:0]   acc_unused;

    // Rise qualification: glitch filter and stall detect. A stalled counter
    // outranks a rise in CALIB/RUN so a wrapped period is never latched.
    always_comb begin
        rise      = clock_cycle & ~cyc_q;
        cnt_inc   = {1'b0, cnt_q} + 1'b1;
        stall     = (cnt_q == CNT_MAX);
        take_rise = rise & ((cnt_inc >= MIN_GAP) || (state_q == ST_IDLE))
                         & ~(stall && (state_q != ST_IDLE));
        load      = take_rise & (state_q != ST_IDLE);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_rise) state_d = ST_CALIB;
            end
            ST_CALIB: begin
                if (stall)          state_d = ST_IDLE;
                else if (take_rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_clear  = load | (state_d != ST_RUN);
    assign acc_enable = (state_q == ST_RUN) & (state_d == ST_RUN) & ~load;

    rotation_slicer_phase_accumulator #(
        .SLICE_LOG    (SLICE_LOG),
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_phase (
        .clock   (clock),
        .reset   (reset),
        .clear   (acc_clear),
        .enable  (acc_enable),
        .period  (period_q),
        .advance (advance),
        .acc     (acc_unused)
    );

    // Output/datapath next values: a rise restarts at slice 0, otherwise
    // advance until the last slice and hold there.
    always_comb begin
        cnt_d    = stall ? cnt_q : cnt_inc[PERIOD_WIDTH-1:0];
        period_d = period_q;
        slice_d  = slice_q;
        strobe_d = 1'b0;
        if (take_rise) begin
            cnt_d = '0;
        end
        if (load) begin
            period_d = cnt_inc[PERIOD_WIDTH-1:0];
            slice_d  = '0;
            strobe_d = 1'b1;
        end else if (state_d != ST_RUN) begin
            slice_d = '0;
        end else if (advance && (slice_q != SLICE_MAX)) begin
            slice_d  = slice_q + 1'b1;
            strobe_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q    <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            slice_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            cyc_q    <= clock_cycle;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            slice_q  <= slice_d;
            strobe_q <= strobe_d;
        end
    end

    assign slice_num    = slice_q;
    assign slice_strobe = strobe_q;
    assign period       = period_q;
    assign running      = (state_q == ST_RUN);

endmodule
